// File: rtl/stopwatch_tx_reporter_pkg.sv
// Shared types and constants for the stopwatch transmit reporter.
package stopwatch_tx_reporter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        SEND = 2'd2,
        WAIT = 2'd3
    } state_t;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;

    // Four digits, optionally followed by CR LF.
    localparam int FRAME_LEN_DIGITS = 4;
    localparam int FRAME_LEN_CRLF   = 6;

    // One BCD nibble as its ASCII digit.
    function automatic logic [7:0] digit_char(input logic [3:0] nib);
        return ASCII_ZERO + {4'h0, nib};
    endfunction

endpackage

// File: rtl/stopwatch_tx_reporter_if.sv
// Report request / count input and UART byte handshake of the reporter.
interface stopwatch_tx_reporter_if #(
    parameter int DIGIT_WIDTH = 14
);
    logic                   i_report;
    logic [DIGIT_WIDTH-1:0] i_digit;
    logic                   i_tx_done;
    logic                   o_tx_start;
    logic [7:0]             o_tx_data;
    logic                   o_busy;
    logic                   o_overrun;

    // The reporter side.
    modport master (
        input  i_report, i_digit, i_tx_done,
        output o_tx_start, o_tx_data, o_busy, o_overrun
    );

    // The environment side: stopwatch, UART and requester.
    modport slave (
        output i_report, i_digit, i_tx_done,
        input  o_tx_start, o_tx_data, o_busy, o_overrun
    );
endinterface

// File: rtl/stopwatch_tx_reporter_bin2bcd_seq.sv
// Iterative double-dabble: one shift per clock, DIGIT_WIDTH shifts per
// conversion, done pulses for one cycle once bcd holds the result.
module bin2bcd_seq #(
    parameter int DIGIT_WIDTH = 14
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [DIGIT_WIDTH-1:0] bin,
    output logic                   done,
    output logic [15:0]            bcd
);
    localparam int CNT_W = $clog2(DIGIT_WIDTH + 1);

    logic [DIGIT_WIDTH-1:0] shift_q;
    logic [15:0]            bcd_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   run_q;
    logic                   done_q;

    // Add 3 to every nibble >= 5 so the following shift carries correctly.
    function automatic logic [15:0] dabble_adjust(input logic [15:0] b);
        logic [15:0] r;
        r = b;
        for (int i = 0; i < 4; i++) begin
            if (r[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // Shift counter and done pulse; reset abandons any conversion in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            run_q  <= 1'b0;
            done_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                run_q <= 1'b1;
                cnt_q <= CNT_W'(DIGIT_WIDTH);
            end else if (run_q) begin
                cnt_q <= cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    run_q  <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    // Load the binary value on start, then adjust-and-shift it into bcd_q.
    always_ff @(posedge clk) begin
        if (start) begin
            shift_q <= bin;
            bcd_q   <= '0;
        end else if (run_q) begin
            {bcd_q, shift_q} <= {dabble_adjust(bcd_q), shift_q} << 1;
        end
    end

    assign done = done_q;
    assign bcd  = bcd_q;

endmodule

// File: rtl/stopwatch_tx_reporter.sv
// Snapshots the stopwatch count on a report request and streams it to the
// UART transmitter as four ASCII digits, optionally followed by CR LF.
module stopwatch_tx_reporter
    import stopwatch_tx_reporter_pkg::*;
#(
    parameter int DIGIT_WIDTH = 14,
    parameter int MAX_VALUE   = 9999,
    parameter bit SEND_CRLF   = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    stopwatch_tx_reporter_if.master bus
);
    localparam int         FRAME_LEN = SEND_CRLF ? FRAME_LEN_CRLF : FRAME_LEN_DIGITS;
    localparam logic [2:0] LAST_IDX  = 3'(FRAME_LEN - 1);

    state_t                 state_q, state_d;
    logic [2:0]             idx_q, idx_d;
    logic                   overrun_q;
    logic                   conv_start;
    logic                   conv_done;
    logic [15:0]            bcd;
    logic [DIGIT_WIDTH-1:0] snapshot;
    logic                   tx_start;
    logic [7:0]             tx_data;

    // Byte at position idx of the frame, most significant digit first.
    function automatic logic [7:0] frame_char(input logic [2:0] idx, input logic [15:0] b);
        case (idx)
            3'd0:    return digit_char(b[15:12]);
            3'd1:    return digit_char(b[11:8]);
            3'd2:    return digit_char(b[7:4]);
            3'd3:    return digit_char(b[3:0]);
            3'd4:    return ASCII_CR;
            3'd5:    return ASCII_LF;
            default: return 8'h00;
        endcase
    endfunction

    // The converter captures the saturated count itself, so the live input
    // is free to move once the request has been accepted.
    assign snapshot = (bus.i_digit > DIGIT_WIDTH'(MAX_VALUE)) ? DIGIT_WIDTH'(MAX_VALUE)
                                                              : bus.i_digit;

    bin2bcd_seq #(.DIGIT_WIDTH(DIGIT_WIDTH)) u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .start (conv_start),
        .bin   (snapshot),
        .done  (conv_done),
        .bcd   (bcd)
    );

    // Next-state and handshake outputs; i_tx_done only counts in WAIT.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        conv_start = 1'b0;
        tx_start   = 1'b0;
        tx_data    = 8'h00;
        case (state_q)
            IDLE: begin
                if (bus.i_report) begin
                    conv_start = 1'b1;
                    state_d    = CONV;
                end
            end
            CONV: begin
                if (conv_done) begin
                    idx_d   = 3'd0;
                    state_d = SEND;
                end
            end
            SEND: begin
                tx_start = 1'b1;
                tx_data  = frame_char(idx_q, bcd);
                state_d  = WAIT;
            end
            WAIT: begin
                tx_data = frame_char(idx_q, bcd);
                if (bus.i_tx_done) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = SEND;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, char index and the overrun pulse for requests made while busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= 3'd0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            overrun_q <= bus.i_report && (state_q != IDLE);
        end
    end

    assign bus.o_tx_start = tx_start;
    assign bus.o_tx_data  = tx_data;
    assign bus.o_busy     = (state_q != IDLE);
    assign bus.o_overrun  = overrun_q;

endmodule
